// File: rtl/acumulador_8b_pkg.sv
// Shared definitions for the acumulador_8b operand accumulator:
// FSM state encoding, default data width and operand-counter width.
package acumulador_8b_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUMA = 2'd1,
        ST_FIN  = 2'd2
    } estado_t;

endpackage

// File: rtl/acumulador_8b_sumador_comb_w.sv
// Parameterised combinational ripple-carry adder built from a chain of
// full-adder cells; carry propagates from bit 0 upwards.
module sumador_comb_w
    import acumulador_8b_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] suma,
    output logic             cout
);

    logic [WIDTH:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign suma[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[WIDTH];

endmodule

// File: rtl/acumulador_8b.sv
// Accumulates N_OPS operands received over a valid/ready handshake into a
// WIDTH-bit sum with a sticky carry flag, then offers the result downstream.
module acumulador_8b
    import acumulador_8b_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int N_OPS   = 4,
    parameter int SATURAR = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_clear,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_dato,
    output logic             o_ready,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_acc,
    output logic             o_carry,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(N_OPS - 1);

    estado_t            state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [WIDTH-1:0]   suma;
    logic               cout;

    // In saturating mode any overflow, now or earlier in the run, pins the sum.
    function automatic logic [WIDTH-1:0] satura(input logic [WIDTH-1:0] s,
                                                input logic             ovf);
        if (SATURAR != 0 && ovf)
            return '1;
        return s;
    endfunction

    sumador_comb_w #(.WIDTH(WIDTH)) u_sumador (
        .a    (acc_q),
        .b    (i_dato),
        .cin  (1'b0),
        .suma (suma),
        .cout (cout)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        count_d = count_q;

        if (i_clear) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            carry_d = 1'b0;
            count_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_d = ST_SUMA;
                        acc_d   = '0;
                        carry_d = 1'b0;
                        count_d = '0;
                    end
                end
                ST_SUMA: begin
                    if (i_valid) begin
                        acc_d   = satura(suma, cout | carry_q);
                        carry_d = carry_q | cout;
                        count_d = count_q + 1'b1;
                        if (count_q == ULTIMO)
                            state_d = ST_FIN;
                    end
                end
                ST_FIN: begin
                    if (i_ready)
                        state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Handshake outputs are pure state decodes: no input-to-output paths.
    assign o_ready = (state_q == ST_SUMA);
    assign o_valid = (state_q == ST_FIN);
    assign o_acc   = acc_q;
    assign o_carry = carry_q;
    assign o_count = count_q;

endmodule
